// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types: prefetch FSM states, fetch strides and address alignment.
// The Thumb variant is enabled by defining PREFETCH_THUMB_EN.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } prefetch_state_t;

  localparam logic [31:0] FETCH_STRIDE_ARM   = 32'd4;
  localparam logic [31:0] FETCH_STRIDE_THUMB = 32'd2;

  function automatic logic [31:0] align_fetch_addr(input logic [31:0] addr, input logic thumb);
    return thumb ? {addr[31:1], 1'b0} : {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous circular FIFO with flush; DEPTH must be a power of two so the pointers wrap for free.
// Storage is left unreset; only pointers and occupancy are cleared.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);
  import cpu_types_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && reset && !i_flush) r_mem[r_tail] <= i_wdata;
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: fetches sequentially into a queue and redirects on flush.
// Defining PREFETCH_THUMB_EN adds a thumb input selecting 2-byte stride and halfword instructions.
module prefetch_unit #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                flush_addr,
  output logic                       bus_read_en,
  output logic [31:0]                bus_addr,
  input  logic [31:0]                bus_rdata,
  input  logic                       bus_ready,
  output logic                       instr_valid,
  output logic [31:0]                instr_data,
  output logic [31:0]                instr_pc,
  input  logic                       instr_ready,
`ifdef PREFETCH_THUMB_EN
  input  logic                       thumb,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import cpu_types_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  prefetch_state_t r_state;
  prefetch_state_t w_state_next;
  logic [31:0]     r_bus_addr;
  logic            w_thumb;
  logic            w_complete;
  logic            w_pop;
  logic            w_empty;
  logic [31:0]     w_head_data;
  logic [31:0]     w_stride;

`ifdef PREFETCH_THUMB_EN
  localparam int ENTRY_W = 65;
  logic               w_head_thumb;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  assign w_thumb = thumb;
  assign w_wdata = {w_thumb, r_bus_addr, bus_rdata};
  assign {w_head_thumb, instr_pc, w_head_data} = w_rdata;
  // Thumb entries expose only the halfword addressed by the entry's own pc.
  assign instr_data = w_head_thumb ?
                      {16'h0000, (instr_pc[1] ? w_head_data[31:16] : w_head_data[15:0])} :
                      w_head_data;
`else
  localparam int ENTRY_W = 64;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  assign w_thumb = 1'b0;
  assign w_wdata = {r_bus_addr, bus_rdata};
  assign {instr_pc, w_head_data} = w_rdata;
  assign instr_data = w_head_data;
`endif

  assign w_stride    = w_thumb ? FETCH_STRIDE_THUMB : FETCH_STRIDE_ARM;
  assign w_complete  = bus_read_en && bus_ready;
  assign instr_valid = !w_empty;
  assign w_pop       = instr_valid && instr_ready && !flush;
  assign bus_addr    = r_bus_addr;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_complete),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_count (count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = FETCH;
    end else begin
      case (r_state)
        IDLE:    w_state_next = FETCH;
        FETCH:   if (w_complete && !w_pop && count == CW'(DEPTH-1)) w_state_next = FULL;
        FULL:    if (w_pop) w_state_next = FETCH;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Request is combinational so a flush cycle never issues a stale address.
  always_comb begin
    bus_read_en = (r_state == FETCH) && !flush;
  end

  always_ff @(posedge clk) begin
    if (!reset)          r_bus_addr <= RESET_VECTOR;
    else if (flush)      r_bus_addr <= align_fetch_addr(flush_addr, w_thumb);
    else if (w_complete) r_bus_addr <= r_bus_addr + w_stride;
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: directed scenarios plus random traffic against a queue-based model.
// Thumb scenario runs only when PREFETCH_THUMB_EN is defined.
module tb_prefetch_unit;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset, flush, bus_ready, instr_ready;
  logic [31:0]   flush_addr, bus_rdata;
  logic          bus_read_en, instr_valid;
  logic [31:0]   bus_addr, instr_data, instr_pc;
  logic [CW-1:0] count;
`ifdef PREFETCH_THUMB_EN
  logic          thumb;
`endif

  always #5 clk = ~clk;

  prefetch_unit #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .bus_read_en (bus_read_en),
    .bus_addr    (bus_addr),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
`ifdef PREFETCH_THUMB_EN
    .thumb       (thumb),
`endif
    .count       (count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched entries plus the next fetch address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        th;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_addr;
  bit          m_idle;
  bit          m_known = 1'b0;

  function automatic logic m_thumb();
`ifdef PREFETCH_THUMB_EN
    return thumb;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_fetching();
    return !m_idle && (m_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] m_data(input ent_t e);
    if (!e.th) return e.data;
    return {16'h0000, (e.pc[1] ? e.data[31:16] : e.data[15:0])};
  endfunction

  task automatic model_update();
    logic done, pop, th;
    th = m_thumb();
    if (!reset) begin
      m_q.delete();
      m_addr  = 32'h0;
      m_idle  = 1'b1;
      m_known = 1'b1;
    end else if (flush) begin
      m_q.delete();
      m_addr = th ? (flush_addr & ~32'h1) : (flush_addr & ~32'h3);
      m_idle = 1'b0;
    end else begin
      done = m_fetching() && bus_ready;
      pop  = (m_q.size() > 0) && instr_ready;
      if (pop) void'(m_q.pop_front());
      if (done) begin
        m_q.push_back('{pc: m_addr, data: bus_rdata, th: th});
        m_addr = m_addr + (th ? 32'd2 : 32'd4);
      end
      m_idle = 1'b0;
    end
  endtask

  task automatic tick();
    #1;
    if (m_known) begin
      check_val("bus_read_en", 32'(bus_read_en), 32'(m_fetching() && !flush));
      check_val("bus_addr", bus_addr, m_addr);
      check_val("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
      check_val("count", 32'(count), 32'(m_q.size()));
      if (m_q.size() > 0) begin
        check_val("instr_pc", instr_pc, m_q[0].pc);
        check_val("instr_data", instr_data, m_data(m_q[0]));
      end
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; flush_addr = '0; bus_ready = 1'b0;
    bus_rdata = '0; instr_ready = 1'b0;
`ifdef PREFETCH_THUMB_EN
    thumb = 1'b0;
`endif
    @(negedge clk);
    tick(); tick();

    // Reset release with bus always ready and consumer stalled: fill to full.
    reset = 1'b1; bus_ready = 1'b1; instr_ready = 1'b0;
    #1 check_val("idle_no_read", 32'(bus_read_en), 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_rdata = 32'hC0DE_0000 + 32'(i);
      #1 check_val("fill_en", 32'(bus_read_en), 32'h1);
      check_val("fill_addr", bus_addr, 32'(4 * i));
      tick();
    end
    #1 check_val("full_count", 32'(count), 32'd4);
    check_val("full_no_read", 32'(bus_read_en), 32'h0);
    check_val("full_head_pc", instr_pc, 32'h0);

    // One pop from full resumes fetching at 0x10.
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1 check_val("resume_en", 32'(bus_read_en), 32'h1);
    check_val("resume_addr", bus_addr, 32'h10);
    check_val("resume_pc", instr_pc, 32'h4);
    tick();
    bus_ready = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check_val("drain_pc", instr_pc, 32'(4 + 4 * i));
      tick();
    end
    instr_ready = 1'b0;

    // Flush coincident with a completing read.
    flush = 1'b1; flush_addr = 32'h1003; bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1 check_val("flush_no_read", 32'(bus_read_en), 32'h0);
    tick();
    flush = 1'b0; bus_ready = 1'b0;
    #1 check_val("flush_count", 32'(count), 32'h0);
    check_val("flush_addr", bus_addr, 32'h1000);
    check_val("flush_en", 32'(bus_read_en), 32'h1);
    tick();

    // Bus stalls three cycles on address 0x8.
    reset = 1'b0; tick();
    reset = 1'b1; bus_ready = 1'b1; tick();
    tick(); tick();
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check_val("stall_addr", bus_addr, 32'h8);
      check_val("stall_en", 32'(bus_read_en), 32'h1);
      check_val("stall_count", 32'(count), 32'd2);
      tick();
    end
    bus_ready = 1'b1;
    tick();
    #1 check_val("stall_push", 32'(count), 32'd3);
    check_val("stall_next", bus_addr, 32'hC);

    // Reset while a request at 0x20 is outstanding.
    flush = 1'b1; flush_addr = 32'h18; tick();
    flush = 1'b0; tick(); tick();
    bus_ready = 1'b0; tick();
    #1 check_val("pend_addr", bus_addr, 32'h20);
    reset = 1'b0; bus_ready = 1'b1; tick();
    #1 check_val("rst_addr", bus_addr, 32'h0);
    check_val("rst_count", 32'(count), 32'h0);
    check_val("rst_valid", 32'(instr_valid), 32'h0);

    // Address wraps from the top of memory.
    reset = 1'b1; bus_ready = 1'b0; tick();
    flush = 1'b1; flush_addr = 32'hFFFF_FFFF; tick();
    flush = 1'b0; bus_ready = 1'b1;
    #1 check_val("wrap_top", bus_addr, 32'hFFFF_FFFC);
    tick();
    bus_ready = 1'b0;
    #1 check_val("wrap_zero", bus_addr, 32'h0);
    check_val("wrap_pc", instr_pc, 32'hFFFF_FFFC);

`ifdef PREFETCH_THUMB_EN
    thumb = 1'b1; flush = 1'b1; flush_addr = 32'h102; tick();
    flush = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hAAAA_BBBB;
    #1 check_val("thumb_addr", bus_addr, 32'h102);
    tick();
    bus_ready = 1'b0;
    #1 check_val("thumb_data", instr_data, 32'h0000_AAAA);
    check_val("thumb_pc", instr_pc, 32'h102);
    check_val("thumb_next", bus_addr, 32'h104);
    tick();
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 39) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      flush_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      bus_ready   = $urandom_range(0, 1) == 1;
      instr_ready = $urandom_range(0, 1) == 1;
      bus_rdata   = $urandom;
`ifdef PREFETCH_THUMB_EN
      thumb       = $urandom_range(0, 1) == 1;
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  one-cycle redirect request.
REQ-006 SHALL have port flush_addr  input  32  redirect target.
REQ-007 SHALL have port bus_read_en  output  1  fetch request.
REQ-008 SHALL have port bus_addr  output  32  fetch address, registered.
REQ-009 SHALL have port bus_rdata  input  32  fetch data, valid when bus_ready.
REQ-010 SHALL have port bus_ready  input  1  completes request in the cycle it is high with bus_read_en.
REQ-011 SHALL have port instr_valid  output  1  queue non-empty.
REQ-012 SHALL have port instr_data  output  32  head instruction.
REQ-013 SHALL have port instr_pc  output  32  head instruction address.
REQ-014 SHALL have port instr_ready  input  1  consumer pops head when instr_valid.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-016 SHALL implement states IDLE, FETCH, FULL; IDLE->FETCH unconditionally one cycle after reset release.
REQ-017 SHALL assert bus_read_en only in FETCH and never in a flush cycle.
REQ-018 SHALL hold bus_addr and bus_read_en stable while bus_read_en high and bus_ready low.
REQ-019 SHALL on completion push {bus_addr, bus_rdata} at tail and advance bus_addr by the fetch stride next cycle.
REQ-020 SHALL transition FETCH->FULL when a push without pop makes count==DEPTH; FULL->FETCH on any pop.
REQ-021 SHALL pop on instr_valid && instr_ready; pop when empty ignored; simultaneous push+pop leaves count unchanged.
REQ-022 SHALL drive instr_data/instr_pc combinationally from head entry; don't-care when instr_valid low.
REQ-023 SHALL wrap head/tail pointers modulo DEPTH.
REQ-024 SHALL on flush: empty queue, zero pointers, discard any same-cycle bus completion and pop, load bus_addr with aligned flush_addr, enter FETCH.
REQ-025 SHALL issue first request to flush target in cycle after flush.
REQ-026 SHALL keep bus_addr 32-bit, wrapping 32'hFFFF_FFFC->0 silently.

Reset
REQ-027 SHALL, while reset low at a clock edge: state IDLE, count 0, pointers 0, bus_addr RESET_VECTOR, bus_read_en 0, instr_valid 0.
REQ-028 SHALL let reset override flush and any bus completion in the same cycle, including mid-request.

Configuration
REQ-029 SHALL support macro PREFETCH_THUMB_EN.
REQ-030 SHALL with PREFETCH_THUMB_EN add port thumb input 1: stride 2, flush_addr aligned to 2, instr_data = {16'h0, halfword selected by instr_pc[1]}; thumb sampled per fetch and stored per entry.
REQ-031 SHALL without PREFETCH_THUMB_EN omit port thumb: stride 4, flush_addr[1:0] forced 2'b00, instr_data = full word.

Structure
REQ-032 SHALL place prefetch_state_t enum and fetch-stride constants in cpu_types_pkg.
REQ-033 SHALL instantiate one sub-module prefetch_fifo (parametrised synchronous FIFO, push/pop/flush, count) holding entries.

Verification
REQ-034 SHALL test reset release with bus_ready=1 and instr_ready=0 -> reads at 0x0,0x4,0x8,0xC, then FULL, bus_read_en 0, count 4.
REQ-035 SHALL test pop from full queue -> FULL->FETCH, next read at 0x10, instr_pc sequence 0x0,0x4,...
REQ-036 SHALL test flush to 0x1003 coincident with bus_ready -> data discarded, count 0, next bus_addr 0x1000.
REQ-037 SHALL test bus_ready low 3 cycles -> bus_addr 0x8 held stable, single push on fourth cycle.
REQ-038 SHALL test reset low during pending request at 0x20 -> bus_addr 0x0, count 0, instr_valid 0 next cycle.
REQ-039 SHALL test with PREFETCH_THUMB_EN, thumb=1, flush to 0x102, rdata 0xAAAA_BBBB -> instr_data 0x0000AAAA, then next read at 0x104.
